// File: rtl/mux_nway_scan.sv
// mux_nway_scan: N-way W-bit mux with registered valid/ready output.
// Direct mode forwards sel; scan mode round-robins enabled channels, DWELL beats each.
module mux_nway_scan #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 8,
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WAYS*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  input  logic [WAYS-1:0]       chan_en,
  output logic [WIDTH-1:0]      out,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d, osel_q, osel_d, low_en, nxt_en;
  logic [7:0]        dcnt_q, dcnt_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              valid_q, valid_d, load, last;
  logic [WIDTH-1:0]  ch [WAYS];

  for (genvar k = 0; k < WAYS; k++) begin : g_ch
    assign ch[k] = in_bus[k*WIDTH +: WIDTH];
  end

  always_comb begin
    low_en = '0;
    for (int i = WAYS-1; i >= 0; i--)
      if (chan_en[SEL_W'(i)]) low_en = SEL_W'(i);
  end

  // Search descending so the nearest enabled channel above ptr wins; falls back to ptr itself.
  always_comb begin
    nxt_en = ptr_q;
    for (int i = WAYS-1; i >= 1; i--)
      if (chan_en[SEL_W'((int'(ptr_q) + i) % WAYS)]) nxt_en = SEL_W'((int'(ptr_q) + i) % WAYS);
  end

  assign load = !valid_q || out_ready;
  assign last = dcnt_q == 8'(DWELL-1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dcnt_d  = dcnt_q;
    out_d   = out_q;
    osel_d  = osel_q;
    valid_d = valid_q;
    if (load) begin
      if (!mode) begin
        out_d   = int'(sel) < WAYS ? ch[sel] : '0;
        osel_d  = sel;
        valid_d = 1'b1;
        state_d = IDLE;
        ptr_d   = '0;
        dcnt_d  = '0;
      end else if (chan_en == '0) begin
        valid_d = 1'b0;
        state_d = IDLE;
        ptr_d   = '0;
        dcnt_d  = '0;
      end else if (state_q == IDLE) begin
        valid_d = 1'b0;
        state_d = SCAN;
        ptr_d   = low_en;
        dcnt_d  = '0;
      end else if (!chan_en[ptr_q]) begin
        valid_d = 1'b0;
        ptr_d   = nxt_en;
        dcnt_d  = '0;
      end else begin
        out_d   = ch[ptr_q];
        osel_d  = ptr_q;
        valid_d = 1'b1;
        dcnt_d  = last ? 8'd0 : dcnt_q + 8'd1;
        ptr_d   = last ? nxt_en : ptr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      dcnt_q  <= '0;
      out_q   <= '0;
      osel_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dcnt_q  <= dcnt_d;
      out_q   <= out_d;
      osel_q  <= osel_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign out_sel   = osel_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_mux_nway_scan.sv
// tb_mux_nway_scan: directed scoreboard bench for mux_nway_scan (WAYS=8, WIDTH=16, DWELL=4).
module tb_mux_nway_scan;
  typedef struct {logic [15:0] d; logic [2:0] s;} exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_bus;
  logic [2:0]   sel;
  logic         mode;
  logic [7:0]   chan_en;
  logic [15:0]  out;
  logic [2:0]   out_sel;
  logic         out_valid;
  logic         out_ready;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;

  mux_nway_scan #(.WIDTH(16), .WAYS(8), .SEL_W(3), .DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel(sel), .mode(mode),
    .chan_en(chan_en), .out(out), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] chd(input int k);
    return 16'(16'h0100 << k);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input int n);
    exp_t e;
    e.d = chd(k);
    e.s = 3'(k);
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  // Beats are sampled on the falling edge, ahead of the rising edge that accepts them.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        vectors++;
        errors++;
        $error("FAIL unexpected_beat: observed out=%h sel=%0d expected no beat", out, out_sel);
      end else begin
        e = q.pop_front();
        chk("beat_data", 32'(out), 32'(e.d));
        chk("beat_sel", 32'(out_sel), 32'(e.s));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input bit toggle);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      if (toggle) out_ready = (n % 2 == 0);
      tick();
      n++;
    end
    chk("drain_left", 32'(q.size()), 32'd0);
    out_ready = 1'b1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sel", 32'(out_sel), 32'd0);
    q.delete();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 8; k++) in_bus[k*16 +: 16] = chd(k);
    sel = '0; mode = 1'b0; chan_en = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_out", 32'(out), 32'd0);
    rst_n = 1'b1;

    // direct sweep, then async reset while ch7 is held
    for (int k = 0; k < 8; k++) begin
      sel = 3'(k);
      push(k, 1);
      tick();
    end
    chk("sweep_held", 32'(out), 32'h8000);
    rst_pulse();

    // backpressure
    sel = 3'd3;
    push(3, 1);
    tick();
    out_ready = 1'b0;
    sel = 3'd6;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_out", 32'(out), 32'h0800);
      chk("bp_hold_sel", 32'(out_sel), 32'd3);
    end
    out_ready = 1'b1;
    push(6, 1);
    tick();
    chk("bp_release", 32'(out), 32'h4000);
    tick();
    rst_pulse();

    // scan round-robin
    mode = 1'b1; chan_en = 8'b1010_0101;
    tick();
    chk("scan_entry_nobeat", 32'(out_valid), 32'd0);
    push(0, 4); push(2, 4); push(5, 4); push(7, 4); push(0, 4);
    drain(1'b0);
    rst_pulse();

    // scan with stalls
    push(0, 4); push(2, 4); push(5, 4); push(7, 4); push(0, 1);
    drain(1'b1);
    rst_pulse();

    // single enabled channel
    chan_en = 8'b0001_0000;
    push(4, 10);
    drain(1'b0);
    rst_pulse();

    // channel disabled mid-dwell on ch2
    chan_en = 8'b1010_0101;
    push(0, 4); push(2, 2);
    drain(1'b0);
    chan_en = 8'b1010_0001;
    push(2, 1);
    tick();
    chk("disable_gap", 32'(out_valid), 32'd0);
    push(5, 4); push(7, 4); push(0, 4);
    drain(1'b0);

    // mask cleared -> idle, then restart at lowest channel
    chan_en = 8'd0;
    push(5, 1);
    tick();
    chk("mask0_valid", 32'(out_valid), 32'd0);
    tick();
    chk("mask0_idle", 32'(out_valid), 32'd0);
    chan_en = 8'b1010_0101;
    tick();
    chk("reentry_nobeat", 32'(out_valid), 32'd0);
    push(0, 4); push(2, 1);
    drain(1'b0);
    rst_pulse();

    // mode switch mid-dwell on ch2
    mode = 1'b1; chan_en = 8'b1010_0101;
    push(0, 4); push(2, 2);
    drain(1'b0);
    mode = 1'b0; sel = 3'd7;
    push(2, 1); push(7, 1);
    tick();
    chk("mode_direct_out", 32'(out), 32'h8000);
    chk("mode_direct_sel", 32'(out_sel), 32'd7);
    mode = 1'b1;
    tick();
    chk("mode_reentry", 32'(out_valid), 32'd0);
    push(0, 4); push(2, 1);
    drain(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mux_nway_scan.md
Name: mux_nway_scan

Overview:
Parametrised N-way, W-bit multiplexer with registered output and valid/ready output handshake. It is the successor to the combinational 8-way/16-bit mux. It has two modes. Direct mode forwards the externally selected channel. Scan mode walks through the enabled channels round-robin and holds each one for a fixed number of accepted beats. It sits between banks of parallel data sources (registers, RAM read ports) and a single downstream consumer.

Parameters:
WIDTH, 16, data width per channel in bits
WAYS, 8, number of input channels (2..256)
SEL_W, 3, select width; must equal clog2(WAYS)
DWELL, 4, accepted beats per channel in scan mode (1..255)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_bus  input  WAYS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
sel  input  SEL_W  channel select, direct mode only
mode  input  1  0 = direct, 1 = scan
chan_en  input  WAYS  per-channel enable mask, scan mode only
out  output  WIDTH  registered selected data
out_sel  output  SEL_W  index of the channel held in out
out_valid  output  1  out/out_sel hold a beat
out_ready  input  1  consumer accepts beat when out_valid && out_ready

Behaviour:
- Reset (rst_n low, async): out=0, out_sel=0, out_valid=0, scan pointer ptr=0, dwell counter dcnt=0, state=IDLE. Reset mid-beat discards the held beat. First load after release is at the first rising edge with rst_n high.
- Load condition: load = !out_valid || out_ready. When load is false, out, out_sel and out_valid hold, regardless of in_bus, sel, mode or chan_en changes.
- Latency: 1 cycle from the sampled inputs to out.
- Direct mode (mode=0), on each load:
  - out <= in_bus[sel], out_sel <= sel, out_valid <= 1.
  - If sel >= WAYS (non-power-of-2 WAYS): out <= 0, out_sel <= sel, out_valid <= 1.
  - ptr and dcnt are held at 0.
- Scan mode FSM, states IDLE and SCAN:
  - IDLE: entered at reset, when mode=0, or when chan_en==0. Move to SCAN on the first load cycle where mode=1 and chan_en!=0. On entry, ptr <= lowest set bit of chan_en and dcnt <= 0. No beat is emitted on the entry cycle (out_valid <= 0 if load).
  - SCAN, on each load:
    - out <= in_bus[ptr], out_sel <= ptr, out_valid <= 1, dcnt <= dcnt+1.
    - When dcnt reaches DWELL-1, set dcnt <= 0 and ptr <= the next set bit of chan_en strictly above ptr, wrapping modulo WAYS. If ptr is the only enabled channel, ptr is unchanged.
  - Channel disabled mid-dwell: if chan_en[ptr]==0 at a load, emit nothing from it (out_valid <= 0), advance ptr to the next enabled channel, and reset dcnt.
  - chan_en becomes 0 in SCAN: at the next load, out_valid <= 0 and go to IDLE.
  - mode 1->0 at a load: direct behaviour applies that cycle and the FSM goes to IDLE. mode 0->1: enter via the IDLE rule.
- Simultaneous accept and reload: a beat is accepted and a new one loaded in the same cycle, so full throughput is 1 beat/cycle with out_ready held high.
- Pointer arithmetic is modulo WAYS. Indices >= WAYS are never produced in scan mode.

Test Plan:
- Reset/direct sweep: WAYS=8, WIDTH=16, in_k = 16'h0100<<k (ch0=16'h0100 ... ch7=16'h8000), out_ready=1, mode=0. Drive sel=0..7 one per cycle -> out follows one cycle later: 16'h0100, 16'h0200 ... 16'h8000, with out_sel matching. Assert rst_n low mid-sweep -> out=0 and out_valid=0 immediately, with no clock edge.
- Backpressure: direct mode, sel=3, out_ready=0 for 5 cycles while sel changes to 6 -> out holds 16'h0800, out_sel=3. Raise out_ready -> next cycle out=16'h4000.
- Scan round-robin: mode=1, DWELL=4, chan_en=8'b1010_0101, out_ready=1 -> out_sel sequence 0,0,0,0,2,2,2,2,5,5,5,5,7,7,7,7,0..., with the entry cycle producing no beat.
- Scan with stalls: same setup, out_ready toggling 1,0,1,0 -> each channel still yields exactly 4 accepted beats, and dcnt advances only on loads.
- Mask edges: chan_en=8'b0001_0000 -> out_sel=4 forever. Clear chan_en[2] while dwelling on ch2 -> one cycle with out_valid=0, then ch5. Set chan_en=0 -> out_valid=0 and FSM returns to IDLE.
- Mode switch: scan mid-dwell on ch2, set mode=0 with sel=7 -> next beat out=16'h8000. Set mode=1 again -> scan restarts at the lowest enabled channel with dcnt=0.
